// File: rtl/safety_periph_obi_bridge.sv
// OBI data-port to register-interface bridge for the core-local peripherals.
// It handles one access at a time. Accesses that miss the window, and accesses
// that stall past the timeout, complete with an OBI error and ErrVal.

typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
} sp_reg_req_t;

typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
} sp_reg_rsp_t;

module safety_periph_obi_bridge #(
    parameter type               reg_req_t     = sp_reg_req_t,
    parameter type               reg_rsp_t     = sp_reg_rsp_t,
    parameter logic [31:0]       WinBaseAddr   = 32'h0020_0000,
    parameter logic [31:0]       WinSize       = 32'h0001_0000,
    parameter int unsigned       TimeoutCycles = 256,
    parameter logic [31:0]       ErrVal        = 32'hBADCAB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        busy_o
);

    // Wide enough to hold TimeoutCycles-1; TimeoutCycles >= 1 keeps this >= 1.
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e          state_q;
    reg_req_t        req_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     offset;
    logic            hit;

    // Unsigned subtraction makes addresses below the base wrap and miss.
    always_comb begin
        offset = addr_i - WinBaseAddr;
        hit    = (offset < WinSize);
    end

    // Single-access FSM: grant in IDLE, drive the register bus in ACCESS, answer in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            req_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    cnt_q    <= '0;
                    if (req_i) begin
                        if (hit) begin
                            req_q.addr  <= addr_i;
                            req_q.write <= we_i;
                            req_q.wdata <= wdata_i;
                            req_q.wstrb <= be_i;
                            req_q.valid <= 1'b1;
                            state_q     <= StAccess;
                        end else begin
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= ErrVal;
                            state_q  <= StResp;
                        end
                    end
                end
                StAccess: begin
                    // Ready is checked first so it wins over a coinciding timeout.
                    if (reg_rsp_i.ready) begin
                        req_q.valid <= 1'b0;
                        rvalid_q    <= 1'b1;
                        err_q       <= reg_rsp_i.error;
                        if (reg_rsp_i.error) begin
                            rdata_q <= ErrVal;
                        end else if (req_q.write) begin
                            rdata_q <= '0;
                        end else begin
                            rdata_q <= reg_rsp_i.rdata;
                        end
                        state_q <= StResp;
                    end else if (cnt_q == CntLast) begin
                        req_q.valid <= 1'b0;
                        rvalid_q    <= 1'b1;
                        err_q       <= 1'b1;
                        rdata_q     <= ErrVal;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    req_q.valid <= 1'b0;
                    rvalid_q    <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    // Grant is combinational and only offered while idle.
    always_comb begin
        gnt_o     = req_i && (state_q == StIdle);
        busy_o    = (state_q != StIdle);
        rvalid_o  = rvalid_q;
        rdata_o   = rdata_q;
        err_o     = err_q;
        reg_req_o = req_q;
    end

endmodule

// File: tb/tb_safety_periph_obi_bridge.sv
// Directed self-checking bench for safety_periph_obi_bridge (TimeoutCycles = 4).

module tb_safety_periph_obi_bridge;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } tb_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } tb_rsp_t;

    localparam logic [31:0] ErrVal = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    tb_req_t     reg_req;
    tb_rsp_t     reg_rsp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    safety_periph_obi_bridge #(
        .reg_req_t    (tb_req_t),
        .reg_rsp_t    (tb_rsp_t),
        .WinBaseAddr  (32'h0020_0000),
        .WinSize      (32'h0001_0000),
        .TimeoutCycles(4),
        .ErrVal       (ErrVal)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .gnt_o    (gnt),
        .addr_i   (addr),
        .we_i     (we),
        .be_i     (be),
        .wdata_i  (wdata),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .reg_req_o(reg_req),
        .reg_rsp_i(reg_rsp),
        .busy_o   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge; the grant is taken at the following posedge.
    task automatic issue(input string tag, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; addr = a; we = w; be = b; wdata = d;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'd1);
    endtask

    task automatic drop_req();
        req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    endtask

    // In-window read with a zero-wait peripheral returning d.
    task automatic read_ok(input string tag, input logic [31:0] a, input logic [31:0] d);
        issue(tag, a, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        drop_req();
        reg_rsp = '0; reg_rsp.ready = 1'b1; reg_rsp.rdata = d;
        #1;
        check({tag, "_valid"}, 32'(reg_req.valid), 32'd1);
        check({tag, "_addr"}, reg_req.addr, a);
        check({tag, "_write"}, 32'(reg_req.write), 32'd0);
        check({tag, "_rv_early"}, 32'(rvalid), 32'd0);
        @(negedge clk);
        reg_rsp = '0;
        #1;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, d);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_valid_drop"}, 32'(reg_req.valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_rv_end"}, 32'(rvalid), 32'd0);
        check({tag, "_rdata_end"}, rdata, 32'h0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drop_req();
        reg_rsp = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reqlo", reg_req[31:0], 32'h0);
        check("rst_reqhi", reg_req[63:32], 32'h0);
        check("rst_reqtop", 32'(reg_req[69:64]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait read.
        read_ok("t1", 32'h0020_1000, 32'h1234_5678);

        // Write with three wait cycles; ready arrives on the 4th valid cycle,
        // which coincides with the timeout point and must win.
        issue("t2", 32'h0020_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drop_req();
            reg_rsp = '0;
            reg_rsp.ready = (i == 4);
            reg_rsp.rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("t2_valid%0d", i), 32'(reg_req.valid), 32'd1);
            check($sformatf("t2_wstrb%0d", i), 32'(reg_req.wstrb), 32'h3);
            check($sformatf("t2_wdata%0d", i), reg_req.wdata, 32'hA5A5_A5A5);
            check($sformatf("t2_rv%0d", i), 32'(rvalid), 32'd0);
        end
        check("t2_write", 32'(reg_req.write), 32'd1);
        @(negedge clk);
        reg_rsp = '0;
        #1;
        check("t2_rvalid", 32'(rvalid), 32'd1);
        check("t2_err", 32'(err), 32'd0);
        check("t2_rdata", rdata, 32'h0);
        @(negedge clk);

        // Out-of-window reads: below the base and just past the end.
        begin
            logic [31:0] miss_addr [2];
            miss_addr[0] = 32'h0010_0000;
            miss_addr[1] = 32'h0021_0000;
            for (int k = 0; k < 2; k++) begin
                issue($sformatf("t3_%0d", k), miss_addr[k], 1'b0, 4'hF, 32'h0);
                @(negedge clk);
                drop_req();
                #1;
                check($sformatf("t3_%0d_rvalid", k), 32'(rvalid), 32'd1);
                check($sformatf("t3_%0d_err", k), 32'(err), 32'd1);
                check($sformatf("t3_%0d_rdata", k), rdata, ErrVal);
                check($sformatf("t3_%0d_valid", k), 32'(reg_req.valid), 32'd0);
                @(negedge clk);
                #1;
                check($sformatf("t3_%0d_rv_end", k), 32'(rvalid), 32'd0);
            end
        end

        // Timeout: peripheral never readies, valid holds exactly 4 cycles.
        issue("t4", 32'h0020_0020, 1'b0, 4'hF, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drop_req();
            #1;
            check($sformatf("t4_valid%0d", i), 32'(reg_req.valid), 32'd1);
            check($sformatf("t4_rv%0d", i), 32'(rvalid), 32'd0);
        end
        @(negedge clk);
        #1;
        check("t4_valid_drop", 32'(reg_req.valid), 32'd0);
        check("t4_rvalid", 32'(rvalid), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_rdata", rdata, ErrVal);
        read_ok("t4b", 32'h0020_FFFC, 32'hCAFE_F00D);

        // Peripheral error on a read.
        issue("t5", 32'h0020_0100, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        drop_req();
        reg_rsp.ready = 1'b1; reg_rsp.error = 1'b1; reg_rsp.rdata = 32'h1111_2222;
        @(negedge clk);
        reg_rsp = '0;
        #1;
        check("t5_rvalid", 32'(rvalid), 32'd1);
        check("t5_err", 32'(err), 32'd1);
        check("t5_rdata", rdata, ErrVal);
        @(negedge clk);

        // Back-to-back reads with req held high: grants every third cycle.
        req = 1'b1; addr = 32'h0020_0010; we = 1'b0; be = 4'hF;
        reg_rsp = '0; reg_rsp.ready = 1'b1; reg_rsp.rdata = 32'h0BAD_F00D;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            check($sformatf("t6_gnt%0d", c), 32'(gnt), 32'((c % 3) == 0));
            check($sformatf("t6_rv%0d", c), 32'(rvalid), 32'((c % 3) == 2));
        end
        @(negedge clk);
        drop_req();
        reg_rsp = '0;

        // Reset in the middle of an access.
        issue("t7", 32'h0020_0200, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        drop_req();
        #1;
        check("t7_valid", 32'(reg_req.valid), 32'd1);
        check("t7_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t7_valid_async", 32'(reg_req.valid), 32'd0);
        check("t7_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("t7_no_rv%0d", i), 32'(rvalid), 32'd0);
            check($sformatf("t7_idle%0d", i), 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/safety_periph_obi_bridge.md
Name: safety_periph_obi_bridge

Overview: Converts the safety core's OBI-style data-port accesses into a single register-interface transaction toward the core-local peripheral demux (timer, CLIC, TCLS). It sits directly upstream of the core-local peripheral request/response port and drives that port. Only one access is outstanding at a time. Accesses that fall outside the peripheral window, and accesses that stall too long, complete with an OBI error and a fixed error pattern instead of hanging the core.

Parameters:
- reg_req_t, logic, register request struct with fields addr[31:0], write, wdata[31:0], wstrb[3:0], valid.
- reg_rsp_t, logic, register response struct with fields rdata[31:0], error, ready.
- WinBaseAddr, 32'h0020_0000, inclusive start of the peripheral window.
- WinSize, 32'h0001_0000, window size in bytes; the window is [WinBaseAddr, WinBaseAddr+WinSize).
- TimeoutCycles, 256, maximum number of cycles valid may be held without ready; must be ≥1.
- ErrVal, 32'hBADCAB1E, rdata returned on any error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: asynchronous assert, active-high.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  OBI address.
- we_i  in  1  OBI write enable.
- be_i  in  4  OBI byte enables.
- wdata_i  in  32  OBI write data.
- rvalid_o  out  1  OBI response valid.
- rdata_o  out  32  OBI read data.
- err_o  out  1  OBI error.
- reg_req_o  out  reg_req_t  request to the peripheral demux.
- reg_rsp_i  in  reg_rsp_t  response from the peripheral demux.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset state:
  - FSM in IDLE.
  - gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, busy_o=0.
  - reg_req_o all fields 0; timeout counter 0.
- gnt_o is combinational: gnt_o = req_i && state==IDLE. No other state grants.
- On grant (cycle 0):
  - Latch addr, we, be, wdata.
  - Window check: hit = (addr_i - WinBaseAddr) < WinSize, unsigned 32-bit arithmetic, so an address below the base wraps and misses.
  - hit → ACCESS; miss → RESP, with err=1 and rdata=ErrVal.
- ACCESS state:
  - reg_req_o.valid=1 with the latched addr/write/wdata/wstrb, held stable until ready.
  - The timeout counter increments every cycle that valid=1 and ready=0.
  - If reg_rsp_i.ready=1: latch rdata and error → RESP. A read with error=1 returns ErrVal; a read with error=0 returns reg_rsp_i.rdata; a write returns rdata 0.
  - Else if the counter reaches TimeoutCycles-1 → RESP with err=1 and rdata=ErrVal; valid drops the next cycle.
  - If ready and timeout coincide in the same cycle, ready wins and the normal response is used.
- RESP state:
  - rvalid_o=1 for exactly one cycle, with rdata_o and err_o valid.
  - Return to IDLE next cycle; the counter is cleared.
  - rdata_o and err_o are 0 whenever rvalid_o=0.
- Latency, in-window read with zero-wait peripheral: gnt@0, valid@1 with ready@1, rvalid@2. Throughput is one access per 3 cycles minimum.
- Out-of-window access: gnt@0, rvalid@1 with err_o=1. reg_req_o.valid is never asserted.
- OBI request-side inputs are ignored outside the grant cycle. req_i may stay high across a response; the next grant happens in IDLE after RESP.
- Reset asserted mid-access:
  - Immediate return to IDLE; valid drops asynchronously.
  - No rvalid_o is produced for the aborted access.
- busy_o = (state != IDLE).

Test Plan:
- In-window read of 0x0020_1000 with zero-wait peripheral returning 0x1234_5678 → gnt@0, reg valid@1 with addr=0x0020_1000, write=0; rvalid@2, rdata_o=0x1234_5678, err_o=0.
- Write of 0xA5A5_A5A5 with be=4'b0011 to 0x0020_0004, peripheral ready after 3 wait cycles → valid held 4 cycles with wstrb=0011 and wdata stable; rvalid one cycle after ready, err_o=0, rdata_o=0.
- Reads of 0x0010_0000 and 0x0021_0000 (both outside the window) → rvalid one cycle after gnt, err_o=1, rdata_o=0xBADCAB1E; reg valid never asserted.
- Peripheral never readies, TimeoutCycles=4 → valid high for exactly 4 cycles, then rvalid with err_o=1 and rdata_o=0xBADCAB1E; the next access succeeds normally.
- Peripheral returns error=1 on a read → rvalid with err_o=1, rdata_o=0xBADCAB1E.
- req_i held high for back-to-back reads; separately, rst_i pulsed during ACCESS → grants at cycles 0, 3, 6 with no gnt in ACCESS/RESP; after reset, valid=0, busy_o=0, and no rvalid for the aborted access.
